ifu_fetch: RTL and testbench

//  Instruction Fetch Unit: owns the PC and fetches 32-bit instructions over a valid/ready ibus.

---
 rtl/ifu_fetch.sv | 196 +++++++++++++++++++
 tb/tb_ifu_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch - Instruction Fetch Unit
//
// Owns the program counter and fetches one 32-bit instruction at a time over a
// valid/ready instruction bus. Each returned word is buffered together with its
// PC in a small FIFO whose head is presented to the decoder through a
// valid/ready handshake. A redirect (taken branch/jump) flushes the buffer,
// drops any in-flight fetch and restarts fetching at the new PC.
//
// Ports
//   clk             in   1     clock, rising edge
//   rst_b           in   1     asynchronous active-low reset
//   ibus_req_valid  out  1     fetch request valid (registered)
//   ibus_req_addr   out  XLEN  fetch address, word aligned (the PC register)
//   ibus_req_ready  in   1     memory accepts the request
//   ibus_rsp_valid  in   1     instruction word returned (always accepted)
//   ibus_rsp_data   in   XLEN  instruction word
//   redirect_valid  in   1     flush and restart fetch at redirect_pc
//   redirect_pc     in   XLEN  new PC, low two bits ignored
//   inst_valid      out  1     inst/inst_pc hold a valid instruction
//   inst            out  XLEN  instruction at the FIFO head
//   inst_pc         out  XLEN  PC of inst
//   inst_ready      in   1     decoder consumes inst this cycle
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter int unsigned       XLEN       = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = 32'h8000_0000,
  parameter int unsigned       IBUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            ibus_req_valid,
  output logic [XLEN-1:0] ibus_req_addr,
  input  logic            ibus_req_ready,
  input  logic            ibus_rsp_valid,
  input  logic [XLEN-1:0] ibus_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int unsigned      PTR_W   = $clog2(IBUF_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);

  // REQ: issue a fetch when there is room; WAIT: response of a live fetch
  // pending; DROP: response of a flushed fetch pending, to be discarded.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [XLEN-1:0]   pc_s;
  logic [XLEN-1:0]   redirect_aligned_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_s;
  logic [XLEN-1:0]   mem_data_r [IBUF_DEPTH];
  logic [XLEN-1:0]   mem_pc_r   [IBUF_DEPTH];
  logic              req_hs_s;
  logic              push_s;
  logic              pop_s;
  logic              req_valid_s;
  logic              inst_valid_s;

  // The FIFO head drives the decoder directly; head pointer and entries are registers.
  assign inst    = mem_data_r[rd_ptr_r];
  assign inst_pc = mem_pc_r[rd_ptr_r];

  // Next-state, PC and FIFO bookkeeping; a redirect overrides every other event.
  always_comb begin
    state_s            = state_r;
    pc_s               = ibus_req_addr;
    wr_ptr_s           = wr_ptr_r;
    rd_ptr_s           = rd_ptr_r;
    count_s            = count_r;
    redirect_aligned_s = redirect_pc & ~(XLEN'(32'd3));
    req_hs_s           = ibus_req_valid & ibus_req_ready;
    // A response landing in WAIT is only kept when no redirect kills it.
    push_s             = (state_r == ST_WAIT) & ibus_rsp_valid & ~redirect_valid;
    pop_s              = inst_valid & inst_ready & ~redirect_valid;

    case (state_r)
      ST_REQ: begin
        if (req_hs_s) begin
          if (redirect_valid) begin
            state_s = ST_DROP;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (ibus_rsp_valid) begin
          state_s = ST_REQ;
        end else if (redirect_valid) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (ibus_rsp_valid) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_REQ;
      end
    endcase

    if (redirect_valid) begin
      pc_s = redirect_aligned_s;
    end else if (req_hs_s) begin
      pc_s = ibus_req_addr + XLEN'(32'd4);
    end else begin
      pc_s = ibus_req_addr;
    end

    if (redirect_valid) begin
      wr_ptr_s = {PTR_W{1'b0}};
      rd_ptr_s = {PTR_W{1'b0}};
      count_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_W'(1'b1);
        2'b01:   count_s = count_r - CNT_W'(1'b1);
        default: count_s = count_r;
      endcase
    end

    // Request credit is judged on the occupancy the next cycle starts with,
    // i.e. before any pop happening in that cycle.
    req_valid_s  = (state_s == ST_REQ) & (count_s < DEPTH_C);
    inst_valid_s = (count_s != {CNT_W{1'b0}});
  end

  // State, PC, FIFO storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r        <= ST_REQ;
      ibus_req_valid <= 1'b0;
      ibus_req_addr  <= RESET_PC;
      fetch_pc_r     <= {XLEN{1'b0}};
      wr_ptr_r       <= {PTR_W{1'b0}};
      rd_ptr_r       <= {PTR_W{1'b0}};
      count_r        <= {CNT_W{1'b0}};
      inst_valid     <= 1'b0;
      for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
        mem_data_r[i] <= {XLEN{1'b0}};
        mem_pc_r[i]   <= {XLEN{1'b0}};
      end
    end else begin
      state_r        <= state_s;
      ibus_req_valid <= req_valid_s;
      ibus_req_addr  <= pc_s;
      wr_ptr_r       <= wr_ptr_s;
      rd_ptr_r       <= rd_ptr_s;
      count_r        <= count_s;
      inst_valid     <= inst_valid_s;
      // Remember the address of the accepted request; its data returns later.
      if (req_hs_s) begin
        fetch_pc_r <= ibus_req_addr;
      end
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= ibus_rsp_data;
        mem_pc_r[wr_ptr_r]   <= fetch_pc_r;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_fetch - self-checking bench for ifu_fetch.
// An instruction-memory responder with random latency serves the ibus. The
// reference model tracks the architectural instruction stream: the next address
// to be fetched, the next PC the decoder must receive, and how many fetched
// words of the current stream are still unconsumed.
// -----------------------------------------------------------------------------
module tb_ifu_fetch;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ibus_req_valid;
  logic [31:0] ibus_req_addr;
  logic        ibus_req_ready;
  logic        ibus_rsp_valid;
  logic [31:0] ibus_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  ifu_fetch #(.XLEN(XLEN), .RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_b(rst_b),
    .ibus_req_valid(ibus_req_valid), .ibus_req_addr(ibus_req_addr),
    .ibus_req_ready(ibus_req_ready), .ibus_rsp_valid(ibus_rsp_valid),
    .ibus_rsp_data(ibus_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] exp_fetch;
  logic [31:0] exp_cons;
  int          inflight;
  // memory responder
  bit          out_busy;
  logic [31:0] out_addr;
  int          out_wait;
  // stimulus knobs
  int unsigned ready_pct, inst_ready_pct, lat_min, lat_max;
  bit          redirect_req;
  logic [31:0] redirect_tgt;
  // bookkeeping
  int          cyc, last_cons, n_req, n_cons;
  bit          gap_check, expect_flush, hold_valid;
  logic [31:0] hold_inst, hold_pc, last_req_addr, last_cons_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_fetch = RPC; exp_cons = RPC; inflight = 0;
    out_busy = 1'b0; out_wait = 0; out_addr = 32'h0;
    expect_flush = 1'b0; hold_valid = 1'b0; last_cons = -1;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    logic hs;
    ibus_rsp_valid = out_busy && (out_wait == 0);
    ibus_rsp_data  = ibus_rsp_valid ? mem_word(out_addr) : 32'hDEAD_BEEF;
    ibus_req_ready = ($urandom_range(99) < ready_pct);
    inst_ready     = ($urandom_range(99) < inst_ready_pct);
    redirect_valid = redirect_req;
    redirect_pc    = redirect_tgt;

    if (expect_flush) check("flush_clears_inst_valid", {31'd0, inst_valid}, 32'd0);
    if (hold_valid) begin
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst", inst, hold_inst);
      check("hold_pc", inst_pc, hold_pc);
    end

    hs = ibus_req_valid && ibus_req_ready;
    if (hs) begin
      check("req_addr", ibus_req_addr, exp_fetch);
      check("one_outstanding", {31'd0, out_busy}, 32'd0);
      check("credit", (inflight < DEPTH) ? 32'd1 : 32'd0, 32'd1);
      exp_fetch = exp_fetch + 32'd4;
      inflight++; n_req++;
      last_req_addr = ibus_req_addr;
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      check("inst_pc", inst_pc, exp_cons);
      check("inst_data", inst, mem_word(exp_cons));
      if (gap_check && last_cons >= 0) check("issue_gap", cyc - last_cons, 32'd2);
      last_cons = cyc; last_cons_pc = inst_pc;
      exp_cons = exp_cons + 32'd4;
      inflight--; n_cons++;
    end
    if (redirect_valid) begin
      exp_fetch = redirect_tgt & 32'hFFFF_FFFC;
      exp_cons  = redirect_tgt & 32'hFFFF_FFFC;
      inflight  = 0; last_cons = -1;
    end
    expect_flush = redirect_valid;
    hold_valid   = inst_valid && !inst_ready && !redirect_valid;
    hold_inst    = inst; hold_pc = inst_pc;

    if (ibus_rsp_valid) out_busy = 1'b0;
    else if (out_busy) out_wait--;
    if (hs) begin
      out_busy = 1'b1; out_addr = ibus_req_addr;
      out_wait = int'($urandom_range(lat_max, lat_min));
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_next_req(input string tag, input logic [31:0] want);
    int start;
    start = n_req;
    for (int i = 0; i < 40 && n_req == start; i++) cycle();
    check({tag, "_seen"}, (n_req > start) ? 32'd1 : 32'd0, 32'd1);
    check(tag, last_req_addr, want);
  endtask

  task automatic wait_next_inst(input string tag, input logic [31:0] want);
    int start;
    start = n_cons;
    for (int i = 0; i < 40 && n_cons == start; i++) cycle();
    check({tag, "_seen"}, (n_cons > start) ? 32'd1 : 32'd0, 32'd1);
    check(tag, last_cons_pc, want);
  endtask

  task automatic redirect_now(input logic [31:0] tgt);
    redirect_req = 1'b1; redirect_tgt = tgt;
    cycle();
    redirect_req = 1'b0;
  endtask

  initial begin
    int i;
    rst_b = 1'b0;
    ibus_req_ready = 1'b0; ibus_rsp_valid = 1'b0; ibus_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    redirect_req = 1'b0; redirect_tgt = 32'h0;
    cyc = 0; n_req = 0; n_cons = 0; gap_check = 1'b0;
    last_req_addr = 32'h0; last_cons_pc = 32'h0; hold_inst = 32'h0; hold_pc = 32'h0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'd0, ibus_req_valid}, 32'd0);
    check("rst_req_addr", ibus_req_addr, RPC);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    rst_b = 1'b1;

    // 1. Zero-wait bus, decoder always ready: sequential fetch, one inst per 2 cycles
    ready_pct = 100; inst_ready_pct = 100; lat_min = 0; lat_max = 0; gap_check = 1'b1;
    repeat (24) cycle();
    gap_check = 1'b0;
    check("t1_progress", (n_cons >= 10) ? 32'd1 : 32'd0, 32'd1);

    // 2. Decoder stalls 10 cycles: FIFO fills, requests stop, then drains in order
    inst_ready_pct = 0;
    repeat (10) cycle();
    check("t2_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("t2_req_stopped", {31'd0, ibus_req_valid}, 32'd0);
    check("t2_buffered", inflight, DEPTH);
    check("t2_no_outstanding", {31'd0, out_busy}, 32'd0);
    inst_ready_pct = 100;
    repeat (12) cycle();

    // 3. Redirect while a 3-cycle response is pending: late response is dropped
    lat_min = 2; lat_max = 2;
    for (i = 0; i < 20 && !(out_busy && out_wait > 0); i++) cycle();
    check("t3_in_wait", (out_busy && out_wait > 0) ? 32'd1 : 32'd0, 32'd1);
    redirect_now(32'h8000_1000);
    wait_next_req("t3_target_req", 32'h8000_1000);
    wait_next_inst("t3_target_inst", 32'h8000_1000);

    // 4. Redirect together with a request handshake and an instruction handshake
    lat_min = 0; lat_max = 0;
    for (i = 0; i < 20 && !(ibus_req_valid && inst_valid); i++) cycle();
    check("t4_setup", (ibus_req_valid && inst_valid) ? 32'd1 : 32'd0, 32'd1);
    redirect_now(32'h8000_2000);
    check("t4_drop_no_req", {31'd0, ibus_req_valid}, 32'd0);
    check("t4_fifo_empty", {31'd0, inst_valid}, 32'd0);
    wait_next_inst("t4_target_inst", 32'h8000_2000);

    // 5. Misaligned redirect target is word aligned
    redirect_now(32'h8000_0006);
    wait_next_req("t5_aligned_req", 32'h8000_0004);
    wait_next_inst("t5_aligned_inst", 32'h8000_0004);

    // PC wraps modulo 2^32
    redirect_now(32'hFFFF_FFF8);
    repeat (14) cycle();
    check("wrap_reached", (last_cons_pc < 32'h100) ? 32'd1 : 32'd0, 32'd1);

    // 6. Asynchronous reset while waiting with buffered instructions
    inst_ready_pct = 0; lat_min = 2; lat_max = 2;
    for (i = 0; i < 30 && !(inst_valid && out_busy && out_wait > 0); i++) cycle();
    check("t6_setup", (inst_valid && out_busy && out_wait > 0) ? 32'd1 : 32'd0, 32'd1);
    ibus_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #2 rst_b = 1'b0;
    #1;
    check("t6_req_valid", {31'd0, ibus_req_valid}, 32'd0);
    check("t6_req_addr", ibus_req_addr, RPC);
    check("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_inst", inst, 32'd0);
    check("t6_inst_pc", inst_pc, 32'd0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    inst_ready_pct = 100; lat_min = 0; lat_max = 1;
    wait_next_req("t6_restart_req", RPC);
    wait_next_inst("t6_restart_inst", RPC);

    // Random traffic with occasional redirects (some misaligned, some near wrap)
    ready_pct = 70; inst_ready_pct = 60; lat_min = 0; lat_max = 3;
    i = n_cons;
    repeat (700) begin
      redirect_req = ($urandom_range(99) < 3);
      if ($urandom_range(1) == 0) redirect_tgt = $urandom;
      else redirect_tgt = 32'hFFFF_FFE0 | 32'($urandom_range(31));
      cycle();
    end
    redirect_req = 1'b0;
    check("random_progress", (n_cons - i > 50) ? 32'd1 : 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
